// File: rtl/loop_ctrl_pkg.sv
// rtl/loop_ctrl_pkg.sv - shared types and defaults for the loop-run sequencer
package loop_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESET_DP = 2'd1,
        RUN      = 2'd2,
        CAPTURE  = 2'd3
    } state_t;

    localparam int W_DEF          = 13;
    localparam int LFSR_W_DEF     = 16;
    localparam int CNT_W_DEF      = 16;
    localparam int DP_RST_CYC_DEF = 2;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] SEED_RST_DEF = 16'hACE1;

endpackage

// File: rtl/loop_run_ctrl_if.sv
// rtl/loop_run_ctrl_if.sv - control, datapath and result bundle of the loop-run sequencer
// master: harness side (requests, datapath state in; results out)
// slave : loop_run_ctrl
interface loop_run_ctrl_if #(
    parameter int W      = 13,
    parameter int LFSR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic              seed_ld;
    logic [LFSR_W-1:0] seed;
    logic [CNT_W-1:0]  max_cyc;

    logic              dp_rst;
    logic              dp_selector;
    logic [W-1:0]      dp_i;
    logic [W-1:0]      dp_j;
    logic [W-1:0]      dp_k;
    logic [W-1:0]      dp_n;

    logic              busy;
    logic              done;
    logic              res_valid;
    logic [W-1:0]      res_i;
    logic [W-1:0]      res_j;
    logic [W-1:0]      res_k;
    logic [W-1:0]      res_n;
    logic [CNT_W-1:0]  res_cyc;
    logic              res_timeout;
    logic              res_aborted;
    logic [LFSR_W-1:0] lfsr;

    modport master (
        output start, abort, seed_ld, seed, max_cyc, dp_i, dp_j, dp_k, dp_n,
        input  dp_rst, dp_selector, busy, done, res_valid,
        input  res_i, res_j, res_k, res_n, res_cyc, res_timeout, res_aborted, lfsr
    );

    modport slave (
        input  start, abort, seed_ld, seed, max_cyc, dp_i, dp_j, dp_k, dp_n,
        output dp_rst, dp_selector, busy, done, res_valid,
        output res_i, res_j, res_k, res_n, res_cyc, res_timeout, res_aborted, lfsr
    );

endinterface

// File: rtl/sel_lfsr.sv
// rtl/sel_lfsr.sv - Galois LFSR producing a registered selector bit
// Ports: clk, rst_n (async active-low), load/seed (all-zero seed -> SEED_RST),
//        step (advance one shift), sel_bit (bit shifted out by the last step), state
module sel_lfsr
    import loop_ctrl_pkg::*;
#(
    parameter int                LFSR_W   = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_TAPS,
    parameter logic [LFSR_W-1:0] SEED_RST = SEED_RST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic              sel_bit,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] ZERO = '0;

    // sel_bit only moves on a step so the datapath sees a stable selector otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEED_RST;
            sel_bit <= 1'b0;
        end else if (load) begin
            state <= (seed == ZERO) ? SEED_RST : seed;
        end else if (step) begin
            state   <= (state >> 1) ^ (state[0] ? TAPS : ZERO);
            sel_bit <= state[0];
        end
    end

endmodule

// File: rtl/loop_run_ctrl.sv
// rtl/loop_run_ctrl.sv - run sequencer for the loop-arithmetic datapath
// Ports: clk, rst_n (async active-low), bus (loop_run_ctrl_if.slave):
//   start/abort/seed_ld/seed/max_cyc requests, dp_rst/dp_selector to the datapath,
//   dp_i/j/k/n from the datapath, busy/done/res_* results, lfsr state
module loop_run_ctrl
    import loop_ctrl_pkg::*;
#(
    parameter int                W          = W_DEF,
    parameter int                LFSR_W     = LFSR_W_DEF,
    parameter int                CNT_W      = CNT_W_DEF,
    parameter int                DP_RST_CYC = DP_RST_CYC_DEF,
    parameter logic [LFSR_W-1:0] SEED_RST   = SEED_RST_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    loop_run_ctrl_if.slave bus
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_inc, budget;
    logic [3:0]       rst_cnt;
    logic             lfsr_load, lfsr_step;
    logic             fin, fin_timeout, fin_abort;

    // Saturating RUN-cycle count including the current cycle
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    sel_lfsr #(
        .LFSR_W   (LFSR_W),
        .TAPS     (LFSR_W'(LFSR_TAPS)),
        .SEED_RST (SEED_RST)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .step    (lfsr_step),
        .seed    (bus.seed),
        .sel_bit (bus.dp_selector),
        .state   (bus.lfsr)
    );

    always_comb begin
        state_nx    = state;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        fin         = 1'b0;
        fin_timeout = 1'b0;
        fin_abort   = 1'b0;
        case (state)
            IDLE: begin
                // Load happens on the same edge as start accept, so the run uses the new seed
                lfsr_load = bus.seed_ld;
                if (bus.start) state_nx = RESET_DP;
            end
            RESET_DP: begin
                if (bus.abort) begin
                    fin       = 1'b1;
                    fin_abort = 1'b1;
                end else if (rst_cnt == 4'(DP_RST_CYC - 1)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                lfsr_step = 1'b1;
                // Priority: abort, then loop exit, then budget expiry
                if (bus.abort) begin
                    fin       = 1'b1;
                    fin_abort = 1'b1;
                end else if (bus.dp_i >= bus.dp_n) begin
                    fin = 1'b1;
                end else if (cnt_inc == budget) begin
                    fin         = 1'b1;
                    fin_timeout = 1'b1;
                end
            end
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (fin) state_nx = CAPTURE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            budget          <= '0;
            rst_cnt         <= '0;
            bus.res_valid   <= 1'b0;
            bus.res_i       <= '0;
            bus.res_j       <= '0;
            bus.res_k       <= '0;
            bus.res_n       <= '0;
            bus.res_cyc     <= '0;
            bus.res_timeout <= 1'b0;
            bus.res_aborted <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                budget        <= (bus.max_cyc == '0) ? CNT_W'(1) : bus.max_cyc;
                cnt           <= '0;
                rst_cnt       <= '0;
                bus.res_valid <= 1'b0;
            end
            if (state == RESET_DP) rst_cnt <= rst_cnt + 4'd1;
            if (lfsr_step) cnt <= cnt_inc;
            // Results are taken from the datapath values that ended the run, so they
            // are already valid in the CAPTURE cycle alongside done
            if (fin) begin
                bus.res_i       <= bus.dp_i;
                bus.res_j       <= bus.dp_j;
                bus.res_k       <= bus.dp_k;
                bus.res_n       <= bus.dp_n;
                bus.res_cyc     <= lfsr_step ? cnt_inc : cnt;
                bus.res_timeout <= fin_timeout;
                bus.res_aborted <= fin_abort;
                bus.res_valid   <= 1'b1;
            end
        end
    end

    assign bus.dp_rst = (state != RUN);
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == CAPTURE);

endmodule

// File: tb/tb_loop_run_ctrl.sv
// tb/tb_loop_run_ctrl.sv - self-checking bench for loop_run_ctrl
module tb_loop_run_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    loop_run_ctrl_if #(.W(13), .LFSR_W(16), .CNT_W(16)) bus ();

    loop_run_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [12:0] di [256];
    logic [12:0] dj [256];
    logic [12:0] dk [256];
    logic [12:0] dn [256];
    logic [15:0] tap_mask;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] gal(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ tap_mask) : (s >> 1);
    endfunction

    task automatic clear_dp();
        for (int q = 0; q < 256; q++) begin
            di[q] = 13'd0;
            dj[q] = 13'd0;
            dk[q] = 13'd0;
            dn[q] = 13'h1FFF;
        end
    endtask

    // One complete run from IDLE; expectations come from the run rules applied to the arrays
    task automatic do_run(input string name, input logic [15:0] mc, input int abort_at,
                          input logic ld, input logic [15:0] sd, input int sel_cycles,
                          input bit start_busy);
        int bud, er, lat, r, nsel;
        bit eto, eab;
        logic [15:0] m;
        bud = (mc == 16'd0) ? 1 : int'(mc);
        er  = bud;
        eto = 1'b1;
        eab = 1'b0;
        for (int q = 1; q <= bud; q++) begin
            if (q == abort_at) begin er = q; eto = 1'b0; eab = 1'b1; break; end
            if (di[q] >= dn[q]) begin er = q; eto = 1'b0; break; end
        end
        m = (sd == 16'd0) ? 16'hACE1 : sd;

        bus.max_cyc = mc;
        bus.seed_ld = ld;
        bus.seed    = sd;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.seed_ld = 1'b0;
        bus.max_cyc = 16'hFFFF;
        chk($sformatf("%s.busy_acc", name), bus.busy, 1'b1);
        chk($sformatf("%s.rv_clr", name), bus.res_valid, 1'b0);
        if (ld) chk($sformatf("%s.seed", name), bus.lfsr, m);

        lat = 1;
        while (bus.dp_rst === 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk($sformatf("%s.latency", name), lat, 3);

        r    = 1;
        nsel = 0;
        while (bus.dp_rst === 1'b0 && r < 256) begin
            bus.dp_i  = di[r];
            bus.dp_j  = dj[r];
            bus.dp_k  = dk[r];
            bus.dp_n  = dn[r];
            bus.abort = (r == abort_at);
            bus.start = start_busy && (r == 1);
            if (r >= 2 && nsel < sel_cycles) begin
                chk($sformatf("%s.sel%0d", name, r), bus.dp_selector, m[0]);
                m = gal(m);
                nsel++;
            end
            tick();
            r++;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;

        chk($sformatf("%s.run_len", name), r - 1, er);
        chk($sformatf("%s.done", name), bus.done, 1'b1);
        chk($sformatf("%s.res_valid", name), bus.res_valid, 1'b1);
        chk($sformatf("%s.res_cyc", name), bus.res_cyc, er);
        chk($sformatf("%s.timeout", name), bus.res_timeout, eto);
        chk($sformatf("%s.aborted", name), bus.res_aborted, eab);
        chk($sformatf("%s.res_i", name), bus.res_i, di[er]);
        chk($sformatf("%s.res_j", name), bus.res_j, dj[er]);
        chk($sformatf("%s.res_k", name), bus.res_k, dk[er]);
        chk($sformatf("%s.res_n", name), bus.res_n, dn[er]);
        tick();
        chk($sformatf("%s.done_pulse", name), bus.done, 1'b0);
        chk($sformatf("%s.idle", name), bus.busy, 1'b0);
        chk($sformatf("%s.rv_hold", name), bus.res_valid, 1'b1);
    endtask

    initial begin
        int dcnt;
        logic [15:0] mc;
        int ab;

        tap_mask = 16'h0;
        foreach (tap_mask[b]) if (b == 15 || b == 13 || b == 12 || b == 10) tap_mask[b] = 1'b1;

        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.seed_ld = 1'b0;
        bus.seed    = 16'h0;
        bus.max_cyc = 16'h0;
        bus.dp_i    = 13'd0;
        bus.dp_j    = 13'd0;
        bus.dp_k    = 13'd0;
        bus.dp_n    = 13'h1FFF;
        clear_dp();

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst.dp_rst", bus.dp_rst, 1'b1);
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.done", bus.done, 1'b0);
        chk("rst.res_valid", bus.res_valid, 1'b0);
        chk("rst.sel", bus.dp_selector, 1'b0);
        chk("rst.lfsr", bus.lfsr, 16'hACE1);
        chk("rst.res_cyc", bus.res_cyc, 16'd0);

        clear_dp();
        do_run("budget5", 16'd5, 0, 1'b0, 16'h0, 0, 1'b0);

        clear_dp();
        di[4] = 13'd20;
        dn[4] = 13'd20;
        do_run("exit_wins", 16'd4, 0, 1'b0, 16'h0, 0, 1'b0);

        clear_dp();
        do_run("seed0", 16'd30, 0, 1'b1, 16'h0000, 25, 1'b0);
        do_run("seed1", 16'd110, 0, 1'b1, 16'h0001, 100, 1'b0);

        clear_dp();
        do_run("abort", 16'd10, 2, 1'b0, 16'h0, 0, 1'b1);

        for (int it = 0; it < 8; it++) begin
            for (int q = 0; q < 256; q++) begin
                di[q] = 13'($urandom_range(0, 40));
                dj[q] = 13'($urandom);
                dk[q] = 13'($urandom);
                dn[q] = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 40)) : 13'h1FFF;
            end
            mc = 16'($urandom_range(0, 12));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
            do_run($sformatf("rnd%0d", it), mc, ab, 1'b0, 16'h0, 0, 1'b0);
        end

        clear_dp();
        bus.dp_i    = 13'd0;
        bus.dp_n    = 13'h1FFF;
        bus.max_cyc = 16'd20;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("midrst.in_run", bus.dp_rst, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", bus.busy, 1'b0);
        chk("midrst.dp_rst", bus.dp_rst, 1'b1);
        chk("midrst.res_valid", bus.res_valid, 1'b0);
        chk("midrst.res_cyc", bus.res_cyc, 16'd0);
        chk("midrst.lfsr", bus.lfsr, 16'hACE1);
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        repeat (6) begin
            tick();
            if (bus.done === 1'b1) dcnt++;
        end
        chk("midrst.no_done", dcnt, 0);

        clear_dp();
        do_run("budget0", 16'd0, 0, 1'b0, 16'h0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
